// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types and constants used by the AXI-side blocks.
package rv_iopmp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DRAIN,
    WR_RESP
  } err_wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } err_rd_state_e;

endpackage

// File: rtl/rv_iopmp_err_responder.sv
// Completes IOPMP-denied AXI transactions upstream: drains W and answers B,
// or generates a full-length zero-data R burst. One denial in flight per path.
module rv_iopmp_err_responder
  import rv_iopmp_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // denied write handoff
  input  logic                  wr_deny_valid_i,
  output logic                  wr_deny_ready_o,
  input  logic [ID_WIDTH-1:0]   wr_deny_id_i,
  input  logic [7:0]            wr_deny_len_i,
  input  logic                  wr_deny_rs_i,
  // receiver W / B
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  output logic [USER_WIDTH-1:0] b_user_o,
  // denied read handoff
  input  logic                  rd_deny_valid_i,
  output logic                  rd_deny_ready_o,
  input  logic [ID_WIDTH-1:0]   rd_deny_id_i,
  input  logic [7:0]            rd_deny_len_i,
  input  logic                  rd_deny_rs_i,
  // receiver R
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic [USER_WIDTH-1:0] r_user_o,
  output logic                  w_proto_err_o
);

  err_wr_state_e wr_state;
  err_rd_state_e rd_state;
  logic [7:0]    wr_len, wr_cnt;
  logic [7:0]    rd_len, rd_cnt;
  logic          wr_last_beat;

  assign wr_last_beat = (wr_cnt == wr_len);
  assign b_user_o     = '0;
  assign r_user_o     = '0;
  assign r_data_o     = '0;

  // Write path. b_id_o/b_resp_o are loaded at the handoff and only become
  // visible once b_valid_o rises, so no separate latch is needed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state        <= WR_IDLE;
      wr_len          <= '0;
      wr_cnt          <= '0;
      wr_deny_ready_o <= 1'b1;
      w_ready_o       <= 1'b0;
      b_valid_o       <= 1'b0;
      b_id_o          <= '0;
      b_resp_o        <= '0;
      w_proto_err_o   <= 1'b0;
    end else begin
      w_proto_err_o <= 1'b0;
      case (wr_state)
        WR_IDLE: if (wr_deny_valid_i) begin
          wr_len          <= wr_deny_len_i;
          wr_cnt          <= '0;
          b_id_o          <= wr_deny_id_i;
          b_resp_o        <= wr_deny_rs_i ? RESP_OKAY : RESP_SLVERR;
          wr_deny_ready_o <= 1'b0;
          w_ready_o       <= 1'b1;
          wr_state        <= WR_DRAIN;
        end
        WR_DRAIN: if (w_valid_i) begin
          wr_cnt        <= wr_cnt + 8'd1;
          // termination is by count; WLAST only feeds the error flag
          w_proto_err_o <= (w_last_i != wr_last_beat);
          if (wr_last_beat) begin
            w_ready_o <= 1'b0;
            b_valid_o <= 1'b1;
            wr_state  <= WR_RESP;
          end
        end
        WR_RESP: if (b_ready_i) begin
          b_valid_o       <= 1'b0;
          wr_deny_ready_o <= 1'b1;
          wr_state        <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read path. r_last_o is precomputed one beat ahead so it stays registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state        <= RD_IDLE;
      rd_len          <= '0;
      rd_cnt          <= '0;
      rd_deny_ready_o <= 1'b1;
      r_valid_o       <= 1'b0;
      r_id_o          <= '0;
      r_resp_o        <= '0;
      r_last_o        <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: if (rd_deny_valid_i) begin
          rd_len          <= rd_deny_len_i;
          rd_cnt          <= '0;
          r_id_o          <= rd_deny_id_i;
          r_resp_o        <= rd_deny_rs_i ? RESP_OKAY : RESP_SLVERR;
          r_last_o        <= (rd_deny_len_i == 8'd0);
          r_valid_o       <= 1'b1;
          rd_deny_ready_o <= 1'b0;
          rd_state        <= RD_BURST;
        end
        RD_BURST: if (r_ready_i) begin
          if (r_last_o) begin
            r_valid_o       <= 1'b0;
            r_last_o        <= 1'b0;
            rd_deny_ready_o <= 1'b1;
            rd_state        <= RD_IDLE;
          end else begin
            rd_cnt   <= rd_cnt + 8'd1;
            r_last_o <= ((rd_cnt + 8'd1) == rd_len);
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iopmp_err_responder.sv
// Directed plus randomized bench for rv_iopmp_err_responder; expectations come
// from transaction-level rules (beat counts, response codes, WLAST mismatches).
module tb_rv_iopmp_err_responder;
  localparam int IDW = 8;
  localparam int DW  = 64;
  localparam int UW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_deny_valid, wr_deny_ready, wr_deny_rs;
  logic [IDW-1:0] wr_deny_id;
  logic [7:0]     wr_deny_len;
  logic           w_valid, w_ready, w_last;
  logic           b_valid, b_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic [UW-1:0]  b_user;
  logic           rd_deny_valid, rd_deny_ready, rd_deny_rs;
  logic [IDW-1:0] rd_deny_id;
  logic [7:0]     rd_deny_len;
  logic           r_valid, r_ready, r_last;
  logic [IDW-1:0] r_id;
  logic [DW-1:0]  r_data;
  logic [1:0]     r_resp;
  logic [UW-1:0]  r_user;
  logic           w_proto_err;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  rv_iopmp_err_responder #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_deny_valid_i(wr_deny_valid), .wr_deny_ready_o(wr_deny_ready),
    .wr_deny_id_i(wr_deny_id), .wr_deny_len_i(wr_deny_len), .wr_deny_rs_i(wr_deny_rs),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .b_user_o(b_user),
    .rd_deny_valid_i(rd_deny_valid), .rd_deny_ready_o(rd_deny_ready),
    .rd_deny_id_i(rd_deny_id), .rd_deny_len_i(rd_deny_len), .rd_deny_rs_i(rd_deny_rs),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last), .r_user_o(r_user),
    .w_proto_err_o(w_proto_err)
  );

  // cycles during which the protocol-error flag is high
  always @(negedge clk) if (w_proto_err === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic rs);
    return rs ? 2'b00 : 2'b10;
  endfunction

  // One denied write: len+1 W beats, WLAST placed on beat index wlast_pos.
  task automatic do_write(input logic [7:0] id, input logic [7:0] len, input logic rs,
                          input int wlast_pos, input bit rnd);
    int mism = 0;
    int p0;
    int gap;
    p0 = pulse_cnt;
    @(negedge clk);
    chk("wr_idle_ready", wr_deny_ready, 1);
    wr_deny_valid = 1'b1; wr_deny_id = id; wr_deny_len = len; wr_deny_rs = rs;
    @(negedge clk);
    wr_deny_valid = 1'b0;
    chk("wr_ready_drop", wr_deny_ready, 0);
    for (int b = 0; b <= int'(len); b++) begin
      gap = rnd ? $urandom_range(0, 1) : 0;
      repeat (gap) begin
        chk("w_ready_gap", w_ready, 1);
        @(negedge clk);
      end
      chk("w_ready_beat", w_ready, 1);
      chk("b_not_early", b_valid, 0);
      w_valid = 1'b1;
      w_last  = (b == wlast_pos);
      if (w_last != (b == int'(len))) mism++;
      @(negedge clk);
      w_valid = 1'b0; w_last = 1'b0;
    end
    chk("w_ready_done", w_ready, 0);
    gap = rnd ? $urandom_range(0, 2) : 1;
    for (int s = 0; s <= gap; s++) begin
      chk("b_valid", b_valid, 1);
      chk("b_id", b_id, id);
      chk("b_resp", b_resp, exp_resp(rs));
      chk("b_user", b_user, 0);
      if (s == gap) b_ready = 1'b1;
      @(negedge clk);
    end
    b_ready = 1'b0;
    chk("b_valid_clr", b_valid, 0);
    chk("wr_ready_back", wr_deny_ready, 1);
    chk("proto_err_pulses", pulse_cnt - p0, mism);
  endtask

  // One denied read: expects exactly len+1 R beats.
  task automatic do_read(input logic [7:0] id, input logic [7:0] len, input logic rs,
                         input int stall_beat, input bit rnd);
    int nstall;
    @(negedge clk);
    chk("rd_idle_ready", rd_deny_ready, 1);
    rd_deny_valid = 1'b1; rd_deny_id = id; rd_deny_len = len; rd_deny_rs = rs;
    @(negedge clk);
    rd_deny_valid = 1'b0;
    chk("rd_ready_drop", rd_deny_ready, 0);
    for (int b = 0; b <= int'(len); b++) begin
      nstall = (b == stall_beat) ? 2 : (rnd && $urandom_range(0, 2) == 0) ? 1 : 0;
      for (int s = 0; s <= nstall; s++) begin
        chk("r_valid", r_valid, 1);
        chk("r_id", r_id, id);
        chk("r_data", r_data, 0);
        chk("r_resp", r_resp, exp_resp(rs));
        chk("r_last", r_last, (b == int'(len)));
        chk("r_user", r_user, 0);
        if (s == nstall) r_ready = 1'b1;
        @(negedge clk);
      end
      r_ready = 1'b0;
    end
    chk("r_valid_clr", r_valid, 0);
    chk("rd_ready_back", rd_deny_ready, 1);
  endtask

  initial begin
    logic [7:0] wl, rl;
    int wp;
    rst = 1'b1;
    wr_deny_valid = 0; wr_deny_id = 0; wr_deny_len = 0; wr_deny_rs = 0;
    w_valid = 0; w_last = 0; b_ready = 0;
    rd_deny_valid = 0; rd_deny_id = 0; rd_deny_len = 0; rd_deny_rs = 0;
    r_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_deny_ready, 1);
    chk("rst_rd_ready", rd_deny_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_id", b_id, 0);
    chk("rst_b_resp", b_resp, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_proto_err", w_proto_err, 0);
    rst = 1'b0;

    do_write(8'h5A, 8'd3, 1'b0, 3, 0);
    do_read(8'h11, 8'd3, 1'b1, 1, 0);
    do_write(8'h22, 8'd1, 1'b0, 0, 0);

    fork
      do_write(8'hC3, 8'd0, 1'b1, 0, 0);
      do_read(8'h7E, 8'd255, 1'b0, -1, 0);
    join

    // reset in the middle of a 16-beat read, at beat index 10
    @(negedge clk);
    rd_deny_valid = 1'b1; rd_deny_id = 8'h44; rd_deny_len = 8'd15; rd_deny_rs = 1'b0;
    @(negedge clk);
    rd_deny_valid = 1'b0;
    r_ready = 1'b1;
    repeat (10) @(negedge clk);
    r_ready = 1'b0;
    chk("pre_rst_r_valid", r_valid, 1);
    chk("pre_rst_r_last", r_last, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_rd_ready", rd_deny_ready, 1);
    chk("mid_rst_wr_ready", wr_deny_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h33, 8'd0, 1'b1, -1, 0);

    for (int i = 0; i < 20; i++) begin
      wl = 8'($urandom_range(0, 15));
      rl = 8'($urandom_range(0, 15));
      wp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(wl))) : int'(wl);
      fork
        do_write(8'($urandom), wl, 1'($urandom), wp, 1);
        do_read(8'($urandom), rl, 1'($urandom), -1, 1);
      join
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
